// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    localparam int unsigned OVS_DEFAULT = 16;

    // cfg_data_bits encoding
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

    // Number of data bits selected by the encoding.
    function automatic logic [3:0] data_bits_count(input logic [1:0] enc);
        case (enc)
            DATA_BITS_5: return 4'd5;
            DATA_BITS_6: return 4'd6;
            DATA_BITS_7: return 4'd7;
            DATA_BITS_8: return 4'd8;
            default:     return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick prescaler: one-cycle tick every max(div_i,1) clk_i cycles.
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 arst_ni,
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] term;
    logic                 at_term;

    // Terminal count; a divisor of zero behaves as one.
    always_comb begin
        term    = (div_i == '0) ? '0 : div_i - 1'b1;
        at_term = (cnt_q >= term);
        tick_o  = en_i && !clr_i && at_term;
    end

    // Free-running count, held at zero while disabled or cleared.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (!en_i || clr_i) begin
            cnt_q <= '0;
        end else if (at_term) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 2-of-3 majority sampling, parity,
// framing and break detection, and a valid/ready holding register.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned OVS       = OVS_DEFAULT,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_data_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_type_i,
    input  logic                 cfg_stop_bits_i,
    input  logic                 rx_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_perr_o,
    output logic                 rx_ferr_o,
    output logic                 rx_break_o,
    output logic                 rx_overrun_o,
    output logic                 busy_o
);

    localparam int unsigned      CNT_W    = $clog2(OVS);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(OVS / 2);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(OVS / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

    rx_state_e state_q, state_d;

    logic rx_s1_q, rx_sync_q, rx_prev_q;

    // Frame configuration captured at the start edge
    logic [DIV_WIDTH-1:0] div_q;
    logic [1:0]           nbits_q;
    logic                 par_en_q, par_type_q, stop2_q;

    logic [CNT_W-1:0] bit_cnt_q;
    logic [1:0]       smp_q;
    logic [7:0]       shreg_q;
    logic [2:0]       idx_q;
    logic             par_bit_q, ferr_acc_q, stop_idx_q;

    logic [7:0] data_q;
    logic       valid_q, perr_q, ferr_q, break_q, ovr_q;

    logic tick, decide, boundary, bit_val, last_data, break_cond, active;
    logic start_frame, frame_done, brk_det;

    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .arst_ni(arst_ni),
        .clk_i  (clk_i),
        .en_i   (cfg_en_i),
        .clr_i  (start_frame),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_sync_q <= rx_s1_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit timing strobes and the majority-voted bit value.
    always_comb begin
        active     = (state_q != RX_IDLE) && (state_q != RX_BREAK_WAIT);
        decide     = tick && active && (bit_cnt_q == SMP_C);
        boundary   = tick && active && (bit_cnt_q == CNT_LAST);
        bit_val    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
        last_data  = ({1'b0, idx_q} == data_bits_count(nbits_q) - 4'd1);
        break_cond = (shreg_q == '0) && !(par_en_q && par_bit_q) && !bit_val;
    end

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and frame event strobes.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        brk_det     = 1'b0;
        if (!cfg_en_i) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_d     = RX_START;
                        start_frame = 1'b1;
                    end
                end
                RX_START: begin
                    if (decide && bit_val) begin
                        state_d = RX_IDLE;
                    end else if (boundary) begin
                        state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (boundary && last_data) begin
                        state_d = par_en_q ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (boundary) begin
                        state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (decide) begin
                        if (!stop_idx_q && break_cond) begin
                            brk_det = 1'b1;
                            state_d = RX_BREAK_WAIT;
                        end else if (stop_idx_q == stop2_q) begin
                            frame_done = 1'b1;
                            state_d    = RX_IDLE;
                        end
                    end
                end
                RX_BREAK_WAIT: begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Frame datapath: config capture, bit counter, samples and shift register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            div_q      <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            idx_q      <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            stop_idx_q <= 1'b0;
        end else if (!cfg_en_i) begin
            bit_cnt_q <= '0;
        end else if (start_frame) begin
            div_q      <= cfg_div_i;
            nbits_q    <= cfg_data_bits_i;
            par_en_q   <= cfg_parity_en_i;
            par_type_q <= cfg_parity_type_i;
            stop2_q    <= cfg_stop_bits_i;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            idx_q      <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            stop_idx_q <= 1'b0;
        end else if (tick && active) begin
            bit_cnt_q <= (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == SMP_A) smp_q[0] <= rx_sync_q;
            if (bit_cnt_q == SMP_B) smp_q[1] <= rx_sync_q;
            if (decide) begin
                case (state_q)
                    RX_DATA:   shreg_q[idx_q] <= bit_val;
                    RX_PARITY: par_bit_q      <= bit_val;
                    RX_STOP:   if (!bit_val) ferr_acc_q <= 1'b1;
                    default:   ;
                endcase
            end
            // Decision and boundary can share a tick when OVS=4; both apply.
            if (boundary) begin
                if (state_q == RX_DATA) idx_q <= idx_q + 1'b1;
                if (state_q == RX_STOP) stop_idx_q <= 1'b1;
            end
        end
    end

    // Holding register, handshake and one-cycle event pulses.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            break_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            break_q <= brk_det;
            ovr_q   <= 1'b0;
            if (frame_done) begin
                if (!valid_q || rx_ready_i) begin
                    data_q  <= shreg_q;
                    perr_q  <= par_en_q & ((^shreg_q) ^ par_bit_q ^ par_type_q);
                    ferr_q  <= ferr_acc_q | ~bit_val;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign rx_perr_o    = perr_q;
    assign rx_ferr_o    = ferr_q;
    assign rx_break_o   = break_q;
    assign rx_overrun_o = ovr_q;
    assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter OVS, default 16: oversampling ticks per bit; SHALL be even and at least 4.
REQ-002 Parameter DIV_WIDTH, default 16: width of the tick prescaler.
REQ-003 Port clk_i, input, 1: single system clock; all logic SHALL be on clk_i, with no derived or gated clocks.
REQ-004 Port arst_ni, input, 1: asynchronous active-low reset.
REQ-005 Port cfg_en_i, input, 1: receiver enable.
REQ-006 Port cfg_div_i, input, DIV_WIDTH: clk_i cycles per sample tick; 0 SHALL be treated as 1.
REQ-007 Port cfg_data_bits_i, input, 2: data bits per frame; 0=5, 1=6, 2=7, 3=8.
REQ-008 Port cfg_parity_en_i, input, 1: parity bit present.
REQ-009 Port cfg_parity_type_i, input, 1: parity sense; 0=even, 1=odd.
REQ-010 Port cfg_stop_bits_i, input, 1: stop bits; 0=1 stop bit, 1=2 stop bits.
REQ-011 Port rx_i, input, 1: asynchronous serial line, idle high.
REQ-012 Port rx_data_o, output, 8: received data, LSB-aligned, unused upper bits zero.
REQ-013 Ports rx_valid_o (output, 1) and rx_ready_i (input, 1): output valid/ready handshake.
REQ-014 Port rx_perr_o, output, 1: parity error flag qualified by rx_valid_o.
REQ-015 Port rx_ferr_o, output, 1: framing error flag qualified by rx_valid_o.
REQ-016 Port rx_break_o, output, 1: one-cycle pulse on break detection.
REQ-017 Port rx_overrun_o, output, 1: one-cycle pulse when a frame is dropped.
REQ-018 Port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-019 rx_i SHALL pass through a 2-flop synchronizer whose flops reset to 1.
REQ-020 The prescaler SHALL count 0..max(cfg_div_i,1)-1 and assert a one-cycle tick at the terminal count; it counts only while cfg_en_i=1.
REQ-021 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-022 In IDLE, a falling edge of the synchronized line (previous 1, current 0) SHALL enter START, clear the prescaler, clear the bit-tick counter and latch all cfg_* inputs for the frame.
REQ-023 The bit-tick counter SHALL run 0..OVS-1 on ticks; the line SHALL be sampled at counts OVS/2-1, OVS/2 and OVS/2+1, and the bit value is the 2-of-3 majority, decided at count OVS/2+1.
REQ-024 START: a decided 1 is a false start and SHALL return to IDLE with no output; a decided 0 SHALL enter DATA at the next bit boundary.
REQ-025 DATA: bits SHALL be shifted LSB-first, N = latched data-bit count.
REQ-026 PARITY is entered only if parity is enabled; perr = (XOR of the data bits and the parity bit) XOR latched parity type.
REQ-027 STOP: one or two stop bits are checked; any decided 0 SHALL set ferr.
REQ-028 The frame completes at the decision point of the final stop bit, and the state SHALL return to IDLE in the same cycle.
REQ-029 Break: all data bits 0, the parity bit (if enabled) 0 and the first stop bit 0 SHALL pulse rx_break_o, push no data and enter BREAK_WAIT.
REQ-030 BREAK_WAIT SHALL leave to IDLE only once the synchronized line is 1.
REQ-031 On a non-break completion: if rx_valid_o=0, or rx_ready_i=1 in the same cycle, the holding register SHALL load data, perr and ferr and assert rx_valid_o the next cycle.
REQ-032 On a non-break completion with rx_valid_o=1 and rx_ready_i=0, the frame SHALL be discarded, rx_overrun_o pulsed, and the held data left unchanged.
REQ-033 rx_valid_o SHALL drop on the cycle after rx_ready_i=1 is seen while rx_valid_o=1, unless a new frame is loaded on that same cycle.
REQ-034 Frame-completion latency: rx_valid_o SHALL rise exactly 1 cycle after the decision tick of the final stop bit.
REQ-035 cfg_en_i=0 SHALL force IDLE and clear the prescaler and bit counter; the holding register and its handshake SHALL be unaffected.
REQ-036 Changes to cfg_* mid-frame SHALL NOT affect the current frame.

Reset
REQ-037 During arst_ni=0: state IDLE, synchronizer flops at 1, and all counters and shift registers 0.
REQ-038 During arst_ni=0: rx_data_o=0, and rx_valid_o, rx_perr_o, rx_ferr_o, rx_break_o, rx_overrun_o and busy_o all 0.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no output pulse.

Structure
REQ-040 uart_pkg SHALL hold the rx_state_e enum, the data-bits encoding constants and the OVS default.
REQ-041 The prescaler SHALL be the sub-module uart_baud_tick (parameter DIV_WIDTH; ports arst_ni, clk_i, en_i, clr_i, div_i, tick_o).

Verification
REQ-042 Directed scenario: cfg_div=4, OVS=16, 8N1, byte 0xA5, ready held high -> rx_data_o=0xA5, perr=0, ferr=0, rx_valid_o high 1 cycle after the stop-bit decision (about 600 clk after the start edge).
REQ-043 Directed scenario: 7E2, byte 0x35 with a wrong parity bit -> rx_data_o=0x35, perr=1, ferr=0.
REQ-044 Directed scenario: 24-clk low glitch (under half a bit) on an idle line -> return to IDLE, no rx_valid_o, busy_o high then low.
REQ-045 Directed scenario: two frames 0x11 and 0x22 with ready low -> 0x11 held, one rx_overrun_o pulse; then ready high -> 0x11 consumed, valid falls.
REQ-046 Directed scenario: line held low for 20 bit times, 8N1 -> one rx_break_o pulse, no valid; after the line goes high, a following 0x5A is received correctly.
REQ-047 Directed scenario: arst_ni asserted during data bit 3 of a frame -> all outputs 0; after release, the next frame 0xC3 is received correctly.
